// File: rtl/fa_pkg.sv
// Shared constants and result type for the structural ripple-carry adder.
package fa_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  typedef struct packed {
    logic                    carry;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/half_adder.sv
// Combinational half adder cell: the building block of every full-adder bit.
module half_adder (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/fa_structural.sv
// Registered ripple-carry adder built from half-adder pairs, 1-cycle latency.
// Optional signed-overflow output enabled by defining FA_STRUCTURAL_OVERFLOW_EN.
module fa_structural
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef FA_STRUCTURAL_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   cin;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] c1;
  logic [WIDTH-1:0] c2;
  logic [WIDTH-1:0] sum_comb;

  assign cin[0] = c;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    half_adder u_ha0 (
      .sum   (s1[gi]),
      .carry (c1[gi]),
      .x     (a[gi]),
      .y     (b[gi])
    );

    half_adder u_ha1 (
      .sum   (sum_comb[gi]),
      .carry (c2[gi]),
      .x     (s1[gi]),
      .y     (cin[gi])
    );

    assign cin[gi+1] = c1[gi] | c2[gi];
  end

`ifdef FA_STRUCTURAL_OVERFLOW_EN
  // cin[WIDTH-1] is the carry into the MSB; at WIDTH=1 that is c itself.
  logic ovf_comb;
  assign ovf_comb = cin[WIDTH] ^ cin[WIDTH-1];
`endif

  // Operands are only sampled under in_valid so idle-cycle X never reaches state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
`ifdef FA_STRUCTURAL_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_comb;
        carry <= cin[WIDTH];
`ifdef FA_STRUCTURAL_OVERFLOW_EN
        ovf   <= ovf_comb;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fa_structural.sv
// Self-checking bench for fa_structural at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_fa_structural;
  import fa_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid8, c8, out_valid8, carry8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, c1, out_valid1, carry1;
  logic [0:0] a1, b1, sum1;
`ifdef FA_STRUCTURAL_OVERFLOW_EN
  logic       ovf8, ovf1;
`endif

  logic [7:0] exp_sum8;
  logic       exp_carry8, exp_vld8, exp_ovf8;
  logic       exp_sum1, exp_carry1, exp_vld1, exp_ovf1;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  fa_structural #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .a(a8), .b(b8), .c(c8),
    .out_valid(out_valid8), .sum(sum8), .carry(carry8)
`ifdef FA_STRUCTURAL_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  fa_structural #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .a(a1), .b(b1), .c(c1),
    .out_valid(out_valid1), .sum(sum1), .carry(carry1)
`ifdef FA_STRUCTURAL_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  function automatic fa_result_t ref_add(input int unsigned w, input logic [63:0] x,
                                         input logic [63:0] y, input logic ci);
    logic [64:0] full;
    fa_result_t  r;
    full = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    r = '0;
    r.carry = full[w];
    for (int unsigned i = 0; i < w; i++) r.sum[i] = full[i];
    return r;
  endfunction

  // Signed overflow: operands share a sign and the result sign differs.
  function automatic logic ref_ovf(input int unsigned w, input logic [63:0] x,
                                   input logic [63:0] y, input logic [63:0] s);
    return (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
  endfunction

  task automatic clear_model();
    exp_sum8 = '0; exp_carry8 = 1'b0; exp_vld8 = 1'b0; exp_ovf8 = 1'b0;
    exp_sum1 = 1'b0; exp_carry1 = 1'b0; exp_vld1 = 1'b0; exp_ovf1 = 1'b0;
  endtask

  // Drive one cycle on both DUTs, advance the model at the edge, return 1 time unit later.
  task automatic cyc(input logic v8, input logic [7:0] x8, input logic [7:0] y8, input logic z8,
                     input logic v1, input logic x1, input logic y1, input logic z1);
    fa_result_t r;
    @(negedge clk);
    in_valid8 = v8; a8 = x8; b8 = y8; c8 = z8;
    in_valid1 = v1; a1 = x1; b1 = y1; c1 = z1;
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      exp_vld8 = v8;
      if (v8) begin
        r = ref_add(8, {56'd0, x8}, {56'd0, y8}, z8);
        exp_sum8 = r.sum[7:0]; exp_carry8 = r.carry;
        exp_ovf8 = ref_ovf(8, {56'd0, x8}, {56'd0, y8}, r.sum);
      end
      exp_vld1 = v1;
      if (v1) begin
        r = ref_add(1, {63'd0, x1}, {63'd0, y1}, z1);
        exp_sum1 = r.sum[0]; exp_carry1 = r.carry;
        exp_ovf1 = ref_ovf(1, {63'd0, x1}, {63'd0, y1}, r.sum);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b1;
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid8, carry8, sum8} !== 10'd0) begin
        errors++;
        $display("FAIL reset_w8 cyc%0d: got vld=%b c=%b s=%h want 0/0/00", i, out_valid8, carry8, sum8);
      end
      checks++;
      if ({out_valid1, carry1, sum1} !== 3'd0) begin
        errors++;
        $display("FAIL reset_w1 cyc%0d: got vld=%b c=%b s=%b want 0/0/0", i, out_valid1, carry1, sum1);
      end
    end
    rst_n = 1'b1;
    cyc(1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({out_valid1, carry1, sum1} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_w1: got vld=%b c=%b s=%b want 1/1/1", out_valid1, carry1, sum1);
    end
    checks++;
    if ({out_valid8, carry8, sum8} !== {1'b1, 1'b0, 8'h03}) begin
      errors++;
      $display("FAIL reset_release_w8: got vld=%b c=%b s=%h want 1/0/03", out_valid8, carry8, sum8);
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [2:0] p;
    for (int i = 0; i < 8; i++) begin
      p = 3'(i);
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, p[2], p[1], p[0]);
      checks++;
      if ({out_valid1, carry1, sum1} !== {1'b1, tt[i]}) begin
        errors++;
        $display("FAIL truth_table abc=%b: got vld=%b cs=%b%b want 1/%b", p, out_valid1, carry1, sum1, tt[i]);
      end
    end
  endtask

  task automatic test_full_ripple();
    cyc(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({carry8, sum8} !== 9'h100) begin
      errors++;
      $display("FAIL ripple_ff_00_1: got c=%b s=%h want 1/00", carry8, sum8);
    end
    cyc(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({carry8, sum8} !== 9'h1FF) begin
      errors++;
      $display("FAIL ripple_ff_ff_1: got c=%b s=%h want 1/ff", carry8, sum8);
    end
    cyc(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({out_valid8, carry8, sum8, out_valid1, carry1, sum1} !== {10'h200, 3'b100}) begin
      errors++;
      $display("FAIL zeros: got w8 c=%b s=%h w1 c=%b s=%b want all 0", carry8, sum8, carry1, sum1);
    end
  endtask

  task automatic test_hold();
    cyc(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({out_valid8, carry8, sum8} !== {1'b1, 1'b0, 8'h46}) begin
      errors++;
      $display("FAIL hold_load: got vld=%b c=%b s=%h want 1/0/46", out_valid8, carry8, sum8);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) cyc(1'b0, 'x, 'x, 1'bx, 1'b0, 1'bx, 1'bx, 1'bx);
      else cyc(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if ({out_valid8, carry8, sum8} !== {1'b0, 1'b0, 8'h46}) begin
        errors++;
        $display("FAIL hold_cyc%0d: got vld=%b c=%b s=%h want 0/0/46", i, out_valid8, carry8, sum8);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if ({out_valid8, carry8, sum8} !== {exp_vld8, exp_carry8, exp_sum8}) begin
        errors++;
        $display("FAIL random_w8 #%0d: got vld=%b c=%b s=%h want %b/%b/%h", i, out_valid8, carry8, sum8,
                 exp_vld8, exp_carry8, exp_sum8);
      end
      checks++;
      if ({out_valid1, carry1, sum1} !== {exp_vld1, exp_carry1, exp_sum1}) begin
        errors++;
        $display("FAIL random_w1 #%0d: got vld=%b c=%b s=%b want %b/%b/%b", i, out_valid1, carry1, sum1,
                 exp_vld1, exp_carry1, exp_sum1);
      end
`ifdef FA_STRUCTURAL_OVERFLOW_EN
      checks++;
      if ({ovf8, ovf1} !== {exp_ovf8, exp_ovf1}) begin
        errors++;
        $display("FAIL random_ovf #%0d: got w8=%b w1=%b want %b/%b", i, ovf8, ovf1, exp_ovf8, exp_ovf1);
      end
`endif
    end
  endtask

  task automatic test_mid_stream_reset();
    logic [7:0] ra [4];
    logic [7:0] rb [4];
    for (int i = 0; i < 4; i++) begin
      ra[i] = 8'($urandom) | 8'h01; rb[i] = 8'($urandom);
    end
    cyc(1'b1, ra[0], rb[0], 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, ra[1], rb[1], 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #20 rst_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if ({out_valid8, carry8, sum8, out_valid1, carry1, sum1} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_async: got w8 %b/%b/%h w1 %b/%b/%b want all 0", out_valid8, carry8, sum8,
               out_valid1, carry1, sum1);
    end
    #10 rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid8, carry8, sum8} !== 10'd0) begin
      errors++;
      $display("FAIL midreset_release: got vld=%b c=%b s=%h want 0/0/00", out_valid8, carry8, sum8);
    end
    for (int i = 2; i < 5; i++) begin
      if (i < 4) cyc(1'b1, ra[i], rb[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      else cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({out_valid8, carry8, sum8} !== {exp_vld8, exp_carry8, exp_sum8}) begin
        errors++;
        $display("FAIL midreset_after #%0d: got vld=%b c=%b s=%h want %b/%b/%h", i, out_valid8, carry8, sum8,
                 exp_vld8, exp_carry8, exp_sum8);
      end
    end
  endtask

`ifdef FA_STRUCTURAL_OVERFLOW_EN
  task automatic test_overflow();
    cyc(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({carry8, sum8, ovf8} !== {1'b0, 8'h80, 1'b1}) begin
      errors++;
      $display("FAIL ovf_7f_01: got c=%b s=%h ovf=%b want 0/80/1", carry8, sum8, ovf8);
    end
    checks++;
    if ({carry1, sum1, ovf1} !== 3'b011) begin
      errors++;
      $display("FAIL ovf_w1_001: got c=%b s=%b ovf=%b want 0/1/1", carry1, sum1, ovf1);
    end
    cyc(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({carry8, sum8, ovf8} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL ovf_ff_01: got c=%b s=%h ovf=%b want 1/00/0", carry8, sum8, ovf8);
    end
    checks++;
    if ({carry1, sum1, ovf1} !== 3'b110) begin
      errors++;
      $display("FAIL ovf_w1_111: got c=%b s=%b ovf=%b want 1/1/0", carry1, sum1, ovf1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_full_ripple();
    test_hold();
    test_random();
    test_mid_stream_reset();
`ifdef FA_STRUCTURAL_OVERFLOW_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fa_structural.md
Name: fa_structural

Overview:
- Registered, parameterisable ripple-carry adder built structurally from half-adder cells.
- Each bit is a full adder made of two half adders plus an OR gate for carry-out.
- At WIDTH=1 it is the single-bit full adder (a, b, c → sum, carry) that datapath blocks and benches use as the arithmetic primitive.
- Inputs are combined combinationally; results are captured into output registers on the clock.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b, c for capture this cycle.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- c  input  1  carry-in to bit 0.
- out_valid  output  1  sum/carry hold a new result.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry-out of the MSB.

Behaviour:
- Reset: while rst_n=0, sum=0, carry=0 and out_valid=0, independent of clk. Release is synchronous to the next rising edge; that edge may capture.
- Per bit i, the combinational chain is:
  - ha0(a[i], b[i]) → s1, c1
  - ha1(s1, cin_i) → sum_i, c2
  - cout_i = c1 | c2
  - cin_0 = c; cin_{i+1} = cout_i; carry_comb = cout_{WIDTH-1}.
- Arithmetic: {carry, sum} = a + b + c, exactly WIDTH+1 bits, unsigned. No truncation; no saturation.
- Latency is 1 cycle. At a rising edge with in_valid=1:
  - sum and carry load the combinational result.
  - out_valid=1 in the following cycle.
- At a rising edge with in_valid=0:
  - sum and carry hold their previous values.
  - out_valid=0.
- Back-to-back in_valid gives one result per cycle. There is no backpressure and no ready signal.
- Boundaries:
  - All-ones + all-ones + c=1 gives sum = all-ones, carry=1.
  - All-zero inputs with c=0 give 0/0.
  - Carry-in must ripple through all WIDTH bits within one clock period.
- Reset asserted mid-stream clears outputs immediately. Any in-flight result is discarded.
- X on a, b or c while in_valid=0 must not propagate to the outputs.

Optional Feature:
- Macro FA_STRUCTURAL_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit, registered), equal to cout_{WIDTH-1} XOR cout_{WIDTH-2}. This is signed two's-complement overflow.
  - For WIDTH=1, ovf = carry XOR c.
  - Reset value 0; ovf updates on the same edges as sum.
- When undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package fa_pkg holds:
  - FA_DEFAULT_WIDTH = 1
  - FA_MAX_WIDTH = 64
  - a typedef for the {carry, sum} result used by the bench scoreboard.
- Sub-module half_adder has ports sum, carry, x, y, with sum = x^y and carry = x&y. It is purely combinational.
- fa_structural instantiates 2×WIDTH half_adder instances in a generate loop, plus the per-bit OR gates and the output registers.

Test Plan:
- Reset: hold rst_n=0 with a=1, b=1, c=1, in_valid=1 → sum=0, carry=0, out_valid=0 throughout. Deassert → first edge gives sum=1, carry=1.
- Exhaustive 1-bit truth table at WIDTH=1: apply (a,b,c) = 000, 001, 010, 011, 100, 101, 110, 111, one per 100 time units with in_valid=1 → {carry,sum} = 00, 01, 01, 10, 01, 10, 10, 11, each one cycle later.
- Full ripple at WIDTH=8: a=8'hFF, b=8'h00, c=1 → sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF, c=1 → sum=8'hFF, carry=1.
- Hold behaviour: load a=8'h12, b=8'h34, c=0 (result 8'h46), then drive in_valid=0 with random a/b/c for 5 cycles → sum stays 8'h46, carry=0, out_valid=0 after the first cycle.
- Mid-stream reset: stream 4 back-to-back operations and pulse rst_n low between edges → outputs clear immediately, no stale result appears after release.
- With FA_STRUCTURAL_OVERFLOW_EN at WIDTH=8:
  - a=8'h7F, b=8'h01, c=0 → sum=8'h80, carry=0, ovf=1.
  - a=8'hFF, b=8'h01 → sum=8'h00, carry=1, ovf=0.
